// File: rtl/ic_trace_arbiter.sv
// ============================================================================
// Module   : ic_trace_arbiter
// Function : Round-robin arbiter that timestamps debug records and frames them
//            onto a shared byte-wide valid/ready trace channel.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ic_trace_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ*2-1:0]       req_fmt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_byte,
    output logic                       out_last,
    output logic                       busy,
    output logic [15:0]                rec_count
);

    localparam int              ID_W        = $clog2(NUM_REQ);
    localparam int              NBYTES      = DATA_W / 8;
    localparam logic [2:0]      c_LAST_BYTE = 3'(NBYTES - 1);
    localparam logic [ID_W:0]   c_NUM       = (ID_W + 1)'(NUM_REQ);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_HDR   = 3'd1;
    localparam logic [2:0] c_TS_HI = 3'd2;
    localparam logic [2:0] c_TS_LO = 3'd3;
    localparam logic [2:0] c_DATA  = 3'd4;

    logic [2:0]        r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [15:0]       r_ts;
    logic [15:0]       r_ts_cap;
    logic [15:0]       r_rec_count;
    logic [DATA_W-1:0] r_data;
    logic [2:0]        r_cnt;
    logic              r_out_valid;
    logic [7:0]        r_out_byte;
    logic              r_out_last;

    logic [ID_W:0]     w_idx;
    logic [ID_W-1:0]   w_grant;
    logic              w_found;
    logic [DATA_W-1:0] w_gdata;
    logic [1:0]        w_gfmt;
    logic [ID_W-1:0]   w_next_rr;
    logic              w_accept;
    logic              w_hs;

    // Search downward so the candidate closest to r_rr_ptr is the last to win.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W + 1)'(k);
            if (w_idx >= c_NUM) begin
                w_idx = w_idx - c_NUM;
            end
            if (req_valid[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_gdata = '0;
        w_gfmt  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_gdata = req_data[i*DATA_W +: DATA_W];
                w_gfmt  = req_fmt[i*2 +: 2];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == c_IDLE && w_found) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign w_accept  = (r_state == c_IDLE) && w_found;
    assign w_hs      = r_out_valid & out_ready;
    assign w_next_rr = (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_rr_ptr    <= '0;
            r_ts        <= '0;
            r_ts_cap    <= '0;
            r_rec_count <= '0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_byte  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_ts <= r_ts + 16'd1;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_ts_cap    <= r_ts;
                        r_data      <= w_gdata;
                        r_rr_ptr    <= w_next_rr;
                        r_state     <= c_HDR;
                        r_out_valid <= 1'b1;
                        r_out_byte  <= {w_gfmt, 4'(w_grant), 2'b10};
                        r_out_last  <= 1'b0;
                    end
                end
                c_HDR: begin
                    if (w_hs) begin
                        r_state    <= c_TS_HI;
                        r_out_byte <= r_ts_cap[15:8];
                    end
                end
                c_TS_HI: begin
                    if (w_hs) begin
                        r_state    <= c_TS_LO;
                        r_out_byte <= r_ts_cap[7:0];
                    end
                end
                c_TS_LO: begin
                    if (w_hs) begin
                        r_state    <= c_DATA;
                        r_out_byte <= r_data[DATA_W-1 -: 8];
                        r_data     <= r_data << 8;
                        r_cnt      <= '0;
                        r_out_last <= (c_LAST_BYTE == 3'd0);
                    end
                end
                c_DATA: begin
                    if (w_hs) begin
                        if (r_cnt == c_LAST_BYTE) begin
                            r_state     <= c_IDLE;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_byte  <= '0;
                            r_rec_count <= r_rec_count + 16'd1;
                        end else begin
                            r_out_byte <= r_data[DATA_W-1 -: 8];
                            r_data     <= r_data << 8;
                            r_cnt      <= r_cnt + 3'd1;
                            r_out_last <= (r_cnt + 3'd1 == c_LAST_BYTE);
                        end
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_byte  = r_out_byte;
    assign out_last  = r_out_last;
    assign busy      = (r_state != c_IDLE);
    assign rec_count = r_rec_count;

endmodule

`default_nettype wire

// File: tb/tb_ic_trace_arbiter.sv
// ============================================================================
// Module   : tb_ic_trace_arbiter
// Function : Self-checking bench: byte-queue reference model, vector table and
//            directed sequences for ic_trace_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ic_trace_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int NB = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data;
    logic [N*2-1:0]  req_fmt;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_byte;
    logic            out_last;
    logic            busy;
    logic [15:0]     rec_count;

    always #5 clk = ~clk;

    ic_trace_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_fmt(req_fmt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .out_last(out_last),
        .busy(busy), .rec_count(rec_count)
    );

    // Reference model: a queue of the bytes still owed to the sink.
    logic [7:0]  m_q[$];
    int          m_rr;
    logic [15:0] m_ts;
    logic [15:0] m_cnt;
    bit          m_known = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    logic         s_valid, s_last, s_busy;
    logic [7:0]   s_byte;
    logic [N-1:0] s_ready;
    logic [15:0]  s_cnt;

    typedef struct {
        int         rep;
        logic       rst;
        logic [3:0] rv;
        logic       ordy;
        logic       ev;
        logic [7:0] eb;
        logic       el;
    } vec_t;
    vec_t tbl[$];

    task automatic finish_bench();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
            if (n_err >= 50) finish_bench();
        end
    endtask

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        bit          idle;
        int          g;
        logic [DW-1:0] d;
        s_valid = out_valid; s_byte = out_byte; s_last = out_last;
        s_busy  = busy;      s_ready = req_ready; s_cnt = rec_count;
        idle = (m_q.size() == 0);
        g    = model_grant();
        if (m_known) begin
            chk("out_valid", out_valid, idle ? 0 : 1);
            if (!idle) begin
                chk("out_byte", out_byte, m_q[0]);
                chk("out_last", out_last, (m_q.size() == 1) ? 1 : 0);
            end else begin
                chk("out_last_idle", out_last, 0);
            end
            chk("busy", busy, idle ? 0 : 1);
            chk("rec_count", rec_count, m_cnt);
            chk("req_ready", req_ready, (idle && g >= 0) ? (1 << g) : 0);
        end
        if (!rst_n) begin
            m_q.delete(); m_rr = 0; m_ts = 0; m_cnt = 0; m_known = 1'b1;
        end else if (m_known) begin
            if (idle) begin
                if (g >= 0) begin
                    d = req_data[g*DW +: DW];
                    m_q.push_back({req_fmt[g*2 +: 2], 4'(g), 2'b10});
                    m_q.push_back(m_ts[15:8]);
                    m_q.push_back(m_ts[7:0]);
                    for (int b = NB - 1; b >= 0; b--) m_q.push_back(d[b*8 +: 8]);
                    m_rr = (g + 1) % N;
                end
            end else if (out_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_cnt++;
            end
            m_ts++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(int rep, logic rst, logic [3:0] rv, logic ordy,
                       logic ev, logic [7:0] eb, logic el);
        vec_t v;
        v.rep = rep; v.rst = rst; v.rv = rv; v.ordy = ordy;
        v.ev = ev; v.eb = eb; v.el = el;
        tbl.push_back(v);
    endtask

    task automatic add_bytes(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                             logic [DW-1:0] d);
        add(1, 1, 0, 1, 1, b0, 0);
        add(1, 1, 0, 1, 1, b1, 0);
        add(1, 1, 0, 1, 1, b2, 0);
        for (int b = NB - 1; b >= 0; b--) add(1, 1, 0, 1, 1, d[b*8 +: 8], (b == 0));
        add(1, 1, 0, 1, 0, 8'h00, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; out_ready = 1'b1;
        step();
        rst_n = 1'b1;
    endtask

    initial begin : main
        logic [3:0] grants[5];
        logic [3:0] srcs[5];
        logic [3:0] eg[5];
        int         ng, nh, seen;
        bit         newrec;

        rst_n = 1'b0; req_valid = '0; out_ready = 1'b1;
        req_data = {32'hCAFEF00D, 32'h01020304, 32'hDEADBEEF, 32'h11223344};
        req_fmt  = {2'd3, 2'd2, 2'd1, 2'd0};
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_valid", s_valid, 0);
        chk("rst_byte", s_byte, 0);
        chk("rst_last", s_last, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_count", s_cnt, 0);
        chk("rst_ready", s_ready, 0);

        // Idle timestamp, single DEC record at ts=0x12, backpressure at TS_LO.
        add(2, 0, 0, 1, 0, 0, 0);
        add(10, 1, 0, 1, 0, 0, 0);
        add(1, 1, 4'b0001, 1, 0, 0, 0);
        add_bytes(8'h02, 8'h00, 8'h0A, 32'h11223344);
        add(1, 0, 0, 1, 0, 0, 0);
        add(18, 1, 0, 1, 0, 0, 0);
        add(1, 1, 4'b0010, 1, 0, 0, 0);
        add_bytes(8'h46, 8'h00, 8'h12, 32'hDEADBEEF);
        add(1, 0, 0, 1, 0, 0, 0);
        add(3, 1, 0, 1, 0, 0, 0);
        add(1, 1, 4'b0100, 1, 0, 0, 0);
        add(1, 1, 0, 1, 1, 8'h8A, 0);
        add(1, 1, 0, 1, 1, 8'h00, 0);
        add(5, 1, 0, 0, 1, 8'h03, 0);
        add(1, 1, 0, 1, 1, 8'h03, 0);
        for (int b = NB - 1; b >= 0; b--) add(1, 1, 0, 1, 1, 8'(b == 3 ? 1 : b == 2 ? 2 : b == 1 ? 3 : 4), (b == 0));
        add(1, 1, 0, 1, 0, 8'h00, 0);

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                rst_n = tbl[i].rst; req_valid = tbl[i].rv; out_ready = tbl[i].ordy;
                step();
                chk("tbl_valid", s_valid, tbl[i].ev);
                if (tbl[i].ev) begin
                    chk("tbl_byte", s_byte, tbl[i].eb);
                    chk("tbl_last", s_last, tbl[i].el);
                end
            end
        end
        chk("bp_rec_count", rec_count, 1);

        // Round robin with every requester asserting continuously.
        do_reset();
        req_valid = 4'hF;
        eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        grants = '{default: 4'h0};
        srcs   = '{default: 4'hF};
        ng = 0; nh = 0; newrec = 1'b1;
        for (int c = 0; c < 80 && nh < 5; c++) begin
            step();
            if (s_ready != 0 && ng < 5) begin grants[ng] = s_ready; ng++; end
            if (s_valid && newrec && nh < 5) begin srcs[nh] = s_byte[5:2]; nh++; newrec = 1'b0; end
            if (s_valid && s_last) newrec = 1'b1;
        end
        for (int i = 0; i < 5; i++) begin
            chk("rr_grant", grants[i], eg[i]);
            chk("rr_src", srcs[i], (i == 4) ? 0 : i);
        end

        // Reset after the third byte handshake abandons the record.
        do_reset();
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        step(); step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("rstmid_valid", s_valid, 0);
        chk("rstmid_count", s_cnt, 0);
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (s_valid || s_last) seen++;
        end
        chk("rstmid_quiet", seen, 0);
        req_valid = 4'b0011;
        step();
        chk("rstmid_rrptr", s_ready, 4'b0001);
        req_valid = '0;
        step();
        chk("rstmid_hdr", s_byte, 8'h02);
        for (int c = 0; c < 6; c++) step();
        chk("rstmid_lastbyte", s_byte, 8'h44);
        chk("rstmid_lastflag", s_last, 1);

        // Timestamp wrap: record at 0xFFFF, next one at the earliest slot.
        do_reset();
        for (int c = 0; c < 70000 && m_ts != 16'hFFFF; c++) step();
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        step(); chk("wrap_ts_hi", s_byte, 8'hFF);
        step(); chk("wrap_ts_lo", s_byte, 8'hFF);
        for (int c = 0; c < 4; c++) step();
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        step(); chk("wrap2_ts_hi", s_byte, 8'h00);
        step(); chk("wrap2_ts_lo", s_byte, 8'h07);
        for (int c = 0; c < 5; c++) step();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            req_valid = 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
            req_fmt   = 8'($urandom);
            step();
        end

        finish_bench();
    end

endmodule

`default_nettype wire
